// File: rtl/lc3_mem_if.sv
// lc3_mem_if: LC-3 MAR/MDR owner, external memory handshake and keyboard/display registers
module lc3_mem_if #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    output logic [15:0] mdr,
    output logic [15:0] mar,
    output logic        mem_r,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_err,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_data,
    output logic        kb_irq,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_n;
    logic [15:0] addr_q, cnt, dev_rdata;
    logic [7:0] kbdr;
    logic kb_rdy, kb_ie, dsr_rdy;
    logic is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;
    logic in_acc, dev_acc, dev_rd, dev_wr, tmo, ddr_go, rd_load;

    assign is_kbsr   = mar == 16'hFE00;
    assign is_kbdr   = mar == 16'hFE02;
    assign is_dsr    = mar == 16'hFE04;
    assign is_ddr    = mar == 16'hFE06;
    assign is_dev    = is_kbsr | is_kbdr | is_dsr | is_ddr;
    assign in_acc    = state == ACCESS;
    assign dev_acc   = state == IDLE && mio_en && is_dev;
    assign dev_rd    = dev_acc && !r_w;
    assign dev_wr    = dev_acc && r_w;
    assign tmo       = in_acc && !mem_ready && MEM_TIMEOUT > 0 && cnt == 16'(MEM_TIMEOUT - 1);
    assign ddr_go    = dev_wr && is_ddr && dsr_rdy;
    assign rd_load   = ld_mdr && mio_en && !r_w;
    assign dev_rdata = is_kbsr ? {kb_rdy, kb_ie, 14'h0} : is_kbdr ? {8'h00, kbdr} : is_dsr ? {dsr_rdy, 15'h0} : 16'h0;
    assign mem_r     = state == DONE;
    assign mem_req   = in_acc;
    assign mem_we    = in_acc && r_w;
    assign mem_addr  = in_acc ? addr_q : mar;
    assign mem_wdata = mdr;
    assign kb_irq    = kb_rdy && kb_ie;

    // device hits finish on the sampling edge; memory waits for ready or timeout
    always_comb begin
        state_n = state == IDLE ? (mio_en ? (is_dev ? DONE : ACCESS) : IDLE) :
                  in_acc ? ((mem_ready || tmo) ? DONE : ACCESS) : IDLE;
    end

    // FSM state, ACCESS cycle counter and the address frozen for the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= in_acc ? cnt + 16'd1 : '0;
            addr_q <= in_acc ? addr_q : mar;
        end
    end

    // MAR, MDR and the sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mar     <= '0;
            mdr     <= '0;
            mem_err <= 1'b0;
        end else begin
            mar     <= ld_mar ? bus_in : mar;
            mdr     <= (ld_mdr && !mio_en) ? bus_in :
                       (rd_load && dev_acc) ? dev_rdata :
                       (rd_load && in_acc && mem_ready) ? mem_rdata :
                       (rd_load && tmo) ? 16'hDEAD : mdr;
            mem_err <= mem_err || tmo;
        end
    end

    // keyboard status/data and display status/data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kbdr       <= '0;
            kb_rdy     <= 1'b0;
            kb_ie      <= 1'b0;
            dsr_rdy    <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            kbdr       <= kb_strobe ? kb_data : kbdr;
            kb_rdy     <= kb_strobe || (kb_rdy && !(dev_rd && is_kbdr));
            kb_ie      <= (dev_wr && is_kbsr) ? mdr[14] : kb_ie;
            dsr_rdy    <= !ddr_go && (dsr_rdy || disp_ack);
            disp_valid <= ddr_go;
            disp_data  <= ddr_go ? mdr[7:0] : disp_data;
        end
    end
endmodule

// File: tb/tb_lc3_mem_if.sv
// tb_lc3_mem_if: randomized transaction-level check of lc3_mem_if against a behavioural model
module tb_lc3_mem_if;
    localparam int TMO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] bus_in, mem_rdata;
    logic ld_mar, ld_mdr, mio_en, r_w, mem_ready, kb_strobe, disp_ack;
    logic [7:0] kb_data;
    logic [15:0] mdr, mar, mem_addr, mem_wdata;
    logic mem_r, mem_req, mem_we, mem_err, kb_irq, disp_valid;
    logic [7:0] disp_data;
    int vectors = 0, miscompares = 0;

    logic [15:0] e_mar, e_mdr, e_addr;
    logic [7:0] e_kbdr, e_dd;
    logic e_r, e_req, e_we, e_err, e_kbrdy, e_kbie, e_dsr, e_dv;

    lc3_mem_if #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .mdr(mdr), .mar(mar), .mem_r(mem_r),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
        .kb_strobe(kb_strobe), .kb_data(kb_data), .kb_irq(kb_irq),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_dev(input logic [15:0] a);
        return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 16'hFE00;
            1: return 16'hFE02;
            2: return 16'hFE04;
            3: return 16'hFE06;
            4: return 16'hFFFE;
            5: return 16'hFE01;
            6: return 16'h3000 + 16'($urandom_range(0, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        e_mar = 0; e_mdr = 0; e_addr = 0; e_kbdr = 0; e_dd = 0;
        e_r = 0; e_req = 0; e_we = 0; e_err = 0; e_kbrdy = 0; e_kbie = 0; e_dsr = 1; e_dv = 0;
    endtask

    task automatic quiet();
        ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; kb_strobe = 0; disp_ack = 0;
        mem_ready = 0; bus_in = 0; kb_data = 0; mem_rdata = 0;
    endtask

    task automatic noise();
        bus_in = pick_addr();
        ld_mar = $urandom_range(0, 3) == 0;
        kb_strobe = $urandom_range(0, 7) == 0;
        kb_data = 8'($urandom);
        disp_ack = $urandom_range(0, 5) == 0;
        mem_rdata = 16'($urandom);
    endtask

    // one clock edge plus the effects that hold regardless of any access in progress
    task automatic tick();
        @(posedge clk);
        e_dv = 0;
        e_r = 0;
        if (ld_mar) e_mar = bus_in;
        if (ld_mdr && !mio_en) e_mdr = bus_in;
        if (kb_strobe) begin e_kbdr = kb_data; e_kbrdy = 1; end
        if (disp_ack) e_dsr = 1;
        #1;
    endtask

    task automatic idle_cycle();
        quiet();
        noise();
        ld_mdr = $urandom_range(0, 2) == 0;
        if (!ld_mar) bus_in = 16'($urandom);
        mem_ready = $urandom_range(0, 3) == 0;
        tick();
    endtask

    task automatic set_mar(input logic [15:0] v);
        quiet(); ld_mar = 1; bus_in = v; tick();
    endtask

    task automatic set_mdr(input logic [15:0] v);
        quiet(); ld_mdr = 1; bus_in = v; tick();
    endtask

    // one complete access: k is the ACCESS cycle on which mem_ready rises
    task automatic access(input logic w, input int k, input logic [15:0] rdat, input logic nz,
                          input logic kbs, input logic [7:0] kbd, input logic ack);
        logic [15:0] a, om;
        logic okr, oki, ods;
        logic [7:0] okd;
        a = e_mar; om = e_mdr; okr = e_kbrdy; oki = e_kbie; ods = e_dsr; okd = e_kbdr;
        quiet();
        if (nz) noise();
        else begin kb_strobe = kbs; kb_data = kbd; disp_ack = ack; end
        mio_en = 1; r_w = w; ld_mdr = w ? (nz ? 1'($urandom) : 1'b0) : 1'b1;
        tick();
        if (is_dev(a)) begin
            if (!w) e_mdr = a == 16'hFE00 ? {okr, oki, 14'h0} : a == 16'hFE02 ? {8'h00, okd} :
                            a == 16'hFE04 ? {ods, 15'h0} : 16'h0;
            if (!w && a == 16'hFE02) e_kbrdy = kb_strobe;
            if (w && a == 16'hFE00) e_kbie = om[14];
            if (w && a == 16'hFE06 && ods) begin e_dd = om[7:0]; e_dv = 1; e_dsr = 0; end
        end else begin
            e_req = 1; e_we = w; e_addr = a;
            for (int i = 1; i <= k && i <= TMO; i++) begin
                quiet();
                if (nz) noise(); else mem_rdata = rdat;
                mio_en = 1; r_w = w; ld_mdr = w ? (nz ? 1'($urandom) : 1'b0) : 1'b1;
                mem_ready = i == k;
                tick();
                if (i == k) begin
                    if (!w) e_mdr = mem_rdata;
                end else if (i == TMO) begin
                    e_err = 1;
                    if (!w) e_mdr = 16'hDEAD;
                end
            end
            e_req = 0;
        end
        e_r = 1;
        quiet();
        if (nz) noise();
        mio_en = 1; r_w = w; ld_mdr = !w;
        tick();
    endtask

    task automatic rd(input logic [15:0] a);
        set_mar(a);
        access(1'b0, 1, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
    endtask

    // every cycle out of reset, all observable outputs must match the model
    always @(negedge clk) begin
        if (rst) begin
            chk16("mar", mar, e_mar);
            chk16("mdr", mdr, e_mdr);
            chk1("mem_r", mem_r, e_r);
            chk1("mem_req", mem_req, e_req);
            chk1("mem_err", mem_err, e_err);
            chk1("kb_irq", kb_irq, e_kbrdy && e_kbie);
            chk1("disp_valid", disp_valid, e_dv);
            chk16("disp_data", {8'h00, disp_data}, {8'h00, e_dd});
            if (e_req) begin
                chk1("mem_we", mem_we, e_we);
                chk16("mem_addr", mem_addr, e_addr);
                chk16("mem_wdata", mem_wdata, e_mdr);
            end
        end
    end

    initial begin
        model_reset();
        quiet();
        #2 rst = 0;
        #1;
        chk16("reset_mar", mar, 16'h0);
        chk16("reset_mdr", mdr, 16'h0);
        chk1("reset_req", mem_req, 1'b0);
        chk1("reset_r", mem_r, 1'b0);
        chk1("reset_dv", disp_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1 rst = 1;
        set_mar(16'h3000);
        access(1'b0, 4, 16'h1234, 1'b0, 1'b0, 8'h0, 1'b0);
        chk16("mem_read_lit", mdr, 16'h1234);
        set_mdr(16'hBEEF);
        set_mar(16'h4000);
        access(1'b1, 2, 16'h5555, 1'b0, 1'b0, 8'h0, 1'b0);
        chk16("mem_write_mdr_lit", mdr, 16'hBEEF);
        set_mar(16'h5000);
        access(1'b0, 6, 16'h7777, 1'b0, 1'b0, 8'h0, 1'b0);
        chk16("timeout_mdr_lit", mdr, 16'hDEAD);
        chk1("timeout_err_lit", mem_err, 1'b1);
        set_mar(16'h3000);
        quiet(); mio_en = 1; ld_mdr = 1; tick();
        e_req = 1; e_we = 0; e_addr = 16'h3000;
        tick();
        #2 rst = 0;
        #1;
        chk1("async_rst_req", mem_req, 1'b0);
        chk16("async_rst_mar", mar, 16'h0);
        chk1("async_rst_err", mem_err, 1'b0);
        chk1("async_rst_r", mem_r, 1'b0);
        quiet();
        @(posedge clk); @(posedge clk); #1 rst = 1;
        model_reset();
        repeat (3) begin quiet(); tick(); end
        quiet(); kb_strobe = 1; kb_data = 8'h41; tick();
        rd(16'hFE00); chk16("kbsr_set_lit", mdr, 16'h8000);
        rd(16'hFE02); chk16("kbdr_lit", mdr, 16'h0041);
        rd(16'hFE00); chk16("kbsr_clr_lit", mdr, 16'h0000);
        quiet(); kb_strobe = 1; kb_data = 8'h55; tick();
        set_mar(16'hFE02);
        access(1'b0, 1, 16'h0, 1'b0, 1'b1, 8'h66, 1'b0);
        chk16("kb_coinc_old_lit", mdr, 16'h0055);
        rd(16'hFE00); chk16("kb_coinc_rdy_lit", mdr, 16'h8000);
        rd(16'hFE02); chk16("kb_coinc_new_lit", mdr, 16'h0066);
        set_mdr(16'h0042);
        set_mar(16'hFE06);
        access(1'b1, 1, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        chk16("disp_data_lit", {8'h00, disp_data}, 16'h0042);
        rd(16'hFE04); chk16("dsr_busy_lit", mdr, 16'h0000);
        set_mdr(16'h0043);
        set_mar(16'hFE06);
        access(1'b1, 1, 16'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        chk16("disp_drop_lit", {8'h00, disp_data}, 16'h0042);
        quiet(); disp_ack = 1; tick();
        rd(16'hFE04); chk16("dsr_ack_lit", mdr, 16'h8000);
        set_mdr(16'h0077);
        set_mar(16'hFE06);
        access(1'b1, 1, 16'h0, 1'b0, 1'b0, 8'h0, 1'b1);
        rd(16'hFE04); chk16("dsr_coinc_lit", mdr, 16'h0000);
        chk16("disp_coinc_lit", {8'h00, disp_data}, 16'h0077);
        repeat (2500) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            else access(1'($urandom), $urandom_range(1, 6), 16'($urandom), 1'b1, 1'b0, 8'h0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
